// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// instruction fetch (IF) and load/store (DM), with in-order read response routing.
module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_if_req,
   input  logic [ADDR_WIDTH-1:0]     i_if_addr,
   output logic                      o_if_gnt,
   output logic                      o_if_rvalid,
   output logic [DATA_WIDTH-1:0]     o_if_rdata,
   input  logic                      i_dm_req,
   input  logic                      i_dm_we,
   input  logic [ADDR_WIDTH-1:0]     i_dm_addr,
   input  logic [DATA_WIDTH-1:0]     i_dm_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_dm_be,
   output logic                      o_dm_gnt,
   output logic                      o_dm_rvalid,
   output logic [DATA_WIDTH-1:0]     o_dm_rdata,
   output logic                      o_mem_en,
   output logic                      o_mem_we,
   output logic [ADDR_WIDTH-1:0]     o_mem_addr,
   output logic [DATA_WIDTH-1:0]     o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   o_mem_be,
   input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } owner_e;

   owner_e                  lastGnt_q, lastGnt_d;
   logic [READ_LATENCY-1:0] tagValid_q;
   logic [READ_LATENCY-1:0] tagOwner_q;
   logic                    tagValid_d;
   logic                    tagOwner_d;
   logic                    ifGnt;
   logic                    dmGnt;

   // Grants are suppressed while reset is asserted so nothing issues during reset.
   always_comb begin
      ifGnt = 1'b0;
      dmGnt = 1'b0;
      if (i_reset_n) begin
         if (i_if_req && i_dm_req) begin
            ifGnt = (lastGnt_q == OWNER_DM);
            dmGnt = (lastGnt_q == OWNER_IF);
         end else begin
            ifGnt = i_if_req;
            dmGnt = i_dm_req;
         end
      end
   end

   always_comb begin
      o_mem_en    = ifGnt | dmGnt;
      o_mem_we    = dmGnt & i_dm_we;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_be    = '0;
      if (dmGnt) begin
         o_mem_addr = i_dm_addr;
         if (i_dm_we) begin
            o_mem_wdata = i_dm_wdata;
            o_mem_be    = i_dm_be;
         end
      end else if (ifGnt) begin
         o_mem_addr = i_if_addr;
      end
   end

   // Owner tag bit: 0 = fetch, 1 = data port.
   always_comb begin
      lastGnt_d = lastGnt_q;
      if (dmGnt) begin
         lastGnt_d = OWNER_DM;
      end else if (ifGnt) begin
         lastGnt_d = OWNER_IF;
      end
      tagValid_d = o_mem_en & ~o_mem_we;
      tagOwner_d = dmGnt;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         lastGnt_q  <= OWNER_DM;
         tagValid_q <= '0;
         tagOwner_q <= '0;
      end else begin
         lastGnt_q     <= lastGnt_d;
         tagValid_q[0] <= tagValid_d;
         tagOwner_q[0] <= tagOwner_d;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tagValid_q[i] <= tagValid_q[i-1];
            tagOwner_q[i] <= tagOwner_q[i-1];
         end
      end
   end

   assign o_if_gnt    = ifGnt;
   assign o_dm_gnt    = dmGnt;
   assign o_if_rvalid = tagValid_q[READ_LATENCY-1] & ~tagOwner_q[READ_LATENCY-1];
   assign o_dm_rvalid = tagValid_q[READ_LATENCY-1] &  tagOwner_q[READ_LATENCY-1];
   assign o_if_rdata  = i_mem_rdata;
   assign o_dm_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (READ_LATENCY 1 and 3) share one
// stimulus stream, each backed by its own behavioural memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic        ifReq, dmReq, dmWe;
   logic [31:0] ifAddr, dmAddr, dmWdata;
   logic [3:0]  dmBe;

   logic        ifGnt1, ifRvalid1, dmGnt1, dmRvalid1, memEn1, memWe1;
   logic [31:0] ifRdata1, dmRdata1, memAddr1, memWdata1, memRdata1;
   logic [3:0]  memBe1;
   logic        ifGnt3, ifRvalid3, dmGnt3, dmRvalid3, memEn3, memWe3;
   logic [31:0] ifRdata3, dmRdata3, memAddr3, memWdata3, memRdata3;
   logic [3:0]  memBe3;

   int    checks   = 0;
   int    failures = 0;
   string phase    = "init";

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1)) dut1 (
      .i_clk(clk), .i_reset_n(rstN),
      .i_if_req(ifReq), .i_if_addr(ifAddr),
      .o_if_gnt(ifGnt1), .o_if_rvalid(ifRvalid1), .o_if_rdata(ifRdata1),
      .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_addr(dmAddr),
      .i_dm_wdata(dmWdata), .i_dm_be(dmBe),
      .o_dm_gnt(dmGnt1), .o_dm_rvalid(dmRvalid1), .o_dm_rdata(dmRdata1),
      .o_mem_en(memEn1), .o_mem_we(memWe1), .o_mem_addr(memAddr1),
      .o_mem_wdata(memWdata1), .o_mem_be(memBe1), .i_mem_rdata(memRdata1)
   );

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
      .i_clk(clk), .i_reset_n(rstN),
      .i_if_req(ifReq), .i_if_addr(ifAddr),
      .o_if_gnt(ifGnt3), .o_if_rvalid(ifRvalid3), .o_if_rdata(ifRdata3),
      .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_addr(dmAddr),
      .i_dm_wdata(dmWdata), .i_dm_be(dmBe),
      .o_dm_gnt(dmGnt3), .o_dm_rvalid(dmRvalid3), .o_dm_rdata(dmRdata3),
      .o_mem_en(memEn3), .o_mem_we(memWe3), .o_mem_addr(memAddr3),
      .o_mem_wdata(memWdata3), .o_mem_be(memBe3), .i_mem_rdata(memRdata3)
   );

   // Memories preload word at byte address A with 0xA000_0000 + A.
   logic [31:0] mem1 [256];
   logic        mem1Init;
   logic [31:0] rd1;
   always @(posedge clk) begin
      if (mem1Init !== 1'b1) begin
         for (int i = 0; i < 256; i++) mem1[i] <= 32'hA000_0000 + 32'(i * 4);
         mem1Init <= 1'b1;
      end else if (memEn1 && memWe1) begin
         for (int b = 0; b < 4; b++)
            if (memBe1[b]) mem1[memAddr1[9:2]][8*b +: 8] <= memWdata1[8*b +: 8];
      end
      rd1 <= (memEn1 && !memWe1) ? mem1[memAddr1[9:2]] : 32'h0;
   end
   assign memRdata1 = rd1;

   logic [31:0] mem3 [256];
   logic        mem3Init;
   logic [31:0] pipe3 [3];
   always @(posedge clk) begin
      if (mem3Init !== 1'b1) begin
         for (int i = 0; i < 256; i++) mem3[i] <= 32'hA000_0000 + 32'(i * 4);
         mem3Init <= 1'b1;
      end else if (memEn3 && memWe3) begin
         for (int b = 0; b < 4; b++)
            if (memBe3[b]) mem3[memAddr3[9:2]][8*b +: 8] <= memWdata3[8*b +: 8];
      end
      pipe3[0] <= (memEn3 && !memWe3) ? mem3[memAddr3[9:2]] : 32'h0;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign memRdata3 = pipe3[2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s %s observed=0x%08h expected=0x%08h", phase, tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                input logic dReq, input logic dWe, input logic [31:0] dAddr,
                                input logic [31:0] dWd, input logic [3:0] dBe);
      ifReq   = iReq;
      ifAddr  = iAddr;
      dmReq   = dReq;
      dmWe    = dWe;
      dmAddr  = dAddr;
      dmWdata = dWd;
      dmBe    = dBe;
   endtask

   // Checks one cycle at the falling edge, then moves to just after the next rising edge.
   task automatic expectCycle(input logic eIfG, input logic eDmG, input logic eWe,
                              input logic [31:0] eAddr, input logic [3:0] eBe,
                              input logic eIfRv1, input logic eDmRv1, input logic [31:0] eD1,
                              input logic eIfRv3, input logic eDmRv3, input logic [31:0] eD3);
      @(negedge clk);
      checkOutput("if_gnt",    32'(ifGnt1), 32'(eIfG));
      checkOutput("dm_gnt",    32'(dmGnt1), 32'(eDmG));
      checkOutput("mem_en",    32'(memEn1), 32'(eIfG | eDmG));
      checkOutput("mem_we",    32'(memWe1), 32'(eWe));
      checkOutput("mem_addr",  memAddr1, eAddr);
      checkOutput("mem_be",    32'(memBe1), 32'(eBe));
      if (eWe) checkOutput("mem_wdata", memWdata1, dmWdata);
      checkOutput("if_gnt_l3", 32'(ifGnt3), 32'(eIfG));
      checkOutput("dm_gnt_l3", 32'(dmGnt3), 32'(eDmG));
      checkOutput("if_rvalid_l1", 32'(ifRvalid1), 32'(eIfRv1));
      checkOutput("dm_rvalid_l1", 32'(dmRvalid1), 32'(eDmRv1));
      if (eIfRv1) checkOutput("if_rdata_l1", ifRdata1, eD1);
      if (eDmRv1) checkOutput("dm_rdata_l1", dmRdata1, eD1);
      checkOutput("if_rvalid_l3", 32'(ifRvalid3), 32'(eIfRv3));
      checkOutput("dm_rvalid_l3", 32'(dmRvalid3), 32'(eDmRv3));
      if (eIfRv3) checkOutput("if_rdata_l3", ifRdata3, eD3);
      if (eDmRv3) checkOutput("dm_rdata_l3", dmRdata3, eD3);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b0;
      applyStimulus(1, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      phase = "reset";
      checkOutput("if_gnt",    32'(ifGnt1), 32'h0);
      checkOutput("dm_gnt",    32'(dmGnt1), 32'h0);
      checkOutput("mem_en",    32'(memEn1), 32'h0);
      checkOutput("mem_we",    32'(memWe1), 32'h0);
      checkOutput("mem_addr",  memAddr1, 32'h0);
      checkOutput("mem_wdata", memWdata1, 32'h0);
      checkOutput("mem_be",    32'(memBe1), 32'h0);
      checkOutput("rvalid_l1", 32'({ifRvalid1, dmRvalid1}), 32'h0);
      checkOutput("rvalid_l3", 32'({ifRvalid3, dmRvalid3}), 32'h0);
      @(posedge clk);
      #1;
      rstN = 1'b1;

      // IF-only stream of three fetches.
      phase = "if_only";
      applyStimulus(1, 32'h00, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(1, 0, 0, 32'h00, 4'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(1, 32'h04, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(1, 0, 0, 32'h04, 4'h0, 1, 0, 32'hA000_0000, 0, 0, 32'h0);
      applyStimulus(1, 32'h08, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(1, 0, 0, 32'h08, 4'h0, 1, 0, 32'hA000_0004, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 1, 0, 32'hA000_0008, 1, 0, 32'hA000_0000);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0, 32'hA000_0004);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0, 32'hA000_0008);
      doReset();

      // First conflict after reset goes to IF.
      phase = "first_conflict";
      applyStimulus(1, 32'h00, 1, 0, 32'h100, 32'h0, 4'h0);
      expectCycle(1, 0, 0, 32'h00, 4'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0);
      expectCycle(0, 1, 0, 32'h100, 4'h0, 1, 0, 32'hA000_0000, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 1, 32'hA000_0100, 0, 0, 32'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0, 32'hA000_0000);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 1, 32'hA000_0100);

      // Continuous dual requests: even cycles IF (0x10), odd cycles DM (0x20).
      phase = "alternate";
      applyStimulus(1, 32'h10, 1, 0, 32'h20, 32'h0, 4'h0);
      for (int k = 0; k < 8; k++) begin
         expectCycle(k % 2 == 0, k % 2 == 1, 0, (k % 2 == 0) ? 32'h10 : 32'h20, 4'h0,
                     k >= 1 && k % 2 == 1, k >= 1 && k % 2 == 0,
                     (k % 2 == 1) ? 32'hA000_0010 : 32'hA000_0020,
                     k >= 3 && k % 2 == 1, k >= 3 && k % 2 == 0,
                     (k % 2 == 1) ? 32'hA000_0010 : 32'hA000_0020);
      end
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 1, 32'hA000_0020, 0, 1, 32'hA000_0020);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0, 32'hA000_0010);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 1, 32'hA000_0020);

      // Full and partial stores followed by loads of the same words.
      phase = "store_load";
      applyStimulus(0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
      expectCycle(0, 1, 1, 32'h40, 4'hF, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 1, 1, 32'h44, 32'h1234_5678, 4'h3);
      expectCycle(0, 1, 1, 32'h44, 4'h3, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 1, 0, 32'h40, 32'hFFFF_FFFF, 4'hF);
      expectCycle(0, 1, 0, 32'h40, 4'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 1, 0, 32'h44, 32'h0, 4'h0);
      expectCycle(0, 1, 0, 32'h44, 4'h0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 1, 32'hA000_5678, 0, 0, 32'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 1, 32'hA000_5678);

      // Reads in flight when reset hits; last grant before reset is IF.
      phase = "inflight";
      applyStimulus(0, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0);
      expectCycle(0, 1, 0, 32'h100, 4'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(1, 32'h08, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(1, 0, 0, 32'h08, 4'h0, 0, 1, 32'hA000_0100, 0, 0, 32'h0);
      applyStimulus(1, 32'h08, 1, 0, 32'h100, 32'h0, 4'h0);
      #2;
      rstN = 1'b0;
      #1;
      phase = "async_reset";
      checkOutput("if_gnt",    32'(ifGnt1), 32'h0);
      checkOutput("dm_gnt",    32'(dmGnt1), 32'h0);
      checkOutput("mem_en",    32'(memEn1), 32'h0);
      checkOutput("mem_addr",  memAddr1, 32'h0);
      checkOutput("if_rvalid_l1", 32'(ifRvalid1), 32'h0);
      checkOutput("gnt_l3",    32'({ifGnt3, dmGnt3}), 32'h0);
      checkOutput("rvalid_l3", 32'({ifRvalid3, dmRvalid3}), 32'h0);
      @(posedge clk);
      #1;
      rstN = 1'b1;

      phase = "after_reset";
      applyStimulus(1, 32'h08, 1, 0, 32'h100, 32'h0, 4'h0);
      expectCycle(1, 0, 0, 32'h08, 4'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0);
      expectCycle(0, 1, 0, 32'h100, 4'h0, 1, 0, 32'hA000_0008, 0, 0, 32'h0);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 1, 32'hA000_0100, 0, 0, 32'h0);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0, 32'hA000_0008);
      expectCycle(0, 0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 1, 32'hA000_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
